// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// axi_lite_pkg
// Response codes, FSM state encodings and helpers for axi_lite_ram_slave_gen2.
// Revision: 1.0
// ============================================================================
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE    = 2'd0,
      W_COLLECT = 2'd1,
      W_WAIT    = 2'd2,
      W_RESP    = 2'd3
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_DATA = 2'd2
   } rd_state_e;

   // Where the registered read beat takes its data from.
   typedef enum logic [1:0] {
      SRC_ZERO = 2'd0,
      SRC_RAM  = 2'd1,
      SRC_ID   = 2'd2
   } rd_src_e;

   function automatic int log2_fn(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_bram_be.sv
`default_nettype none
// ============================================================================
// axi_lite_bram_be
// Byte-enable RAM: one write port, one registered read port, no reset.
// Revision: 1.0
// ============================================================================
module axi_lite_bram_be #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_W-1:0]     i_waddr,
   input  logic [DATA_W-1:0]     i_wdata,
   input  logic [DATA_W/8-1:0]   i_wstrb,
   input  logic                  i_re,
   input  logic [ADDR_W-1:0]     i_raddr,
   output logic [DATA_W-1:0]     o_rdata
);

   localparam int STRB_W = DATA_W / 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (i_re) begin
         rdata_d = mem[i_raddr];
      end
   end

   // Read and write share an edge, so a same-word collision returns old data.
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (i_wstrb[i]) begin
               mem[i_waddr][i*8 +: 8] <= i_wdata[i*8 +: 8];
            end
         end
      end
      rdata_q <= rdata_d;
   end

   assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/axi_lite_ram_slave_gen2.sv
`default_nettype none
// ============================================================================
// axi_lite_ram_slave_gen2
// AXI4-Lite RAM slave with byte strobes, wait states and SLVERR on out-of-range.
// Optional read-only ID word at word 0 when AXI_SLV_ID_REG_EN is defined.
// Revision: 1.0
// ============================================================================
module axi_lite_ram_slave_gen2
   import axi_lite_pkg::*;
#(
   parameter int          DataWidth_Gen    = 32,
   parameter int          AddrWidth_Gen    = 16,
   parameter int          RamAddrWidth_Gen = 10,
   parameter int          WaitCycles_Gen   = 0,
   parameter logic [31:0] IdValue_Gen      = 32'hDA5A_0002
) (
   input  logic                       SysClk_ClkIn,
   input  logic                       SysRstN_RstIn,
   input  logic                       AxiWriteAddrValid_ValIn,
   output logic                       AxiWriteAddrReady_RdyOut,
   input  logic [AddrWidth_Gen-1:0]   AxiWriteAddrAddress_AdrIn,
   input  logic [2:0]                 AxiWriteAddrProt_DatIn,
   input  logic                       AxiWriteDataValid_ValIn,
   output logic                       AxiWriteDataReady_RdyOut,
   input  logic [DataWidth_Gen-1:0]   AxiWriteDataData_DatIn,
   input  logic [DataWidth_Gen/8-1:0] AxiWriteDataStrobe_DatIn,
   output logic                       AxiWriteRespValid_ValOut,
   input  logic                       AxiWriteRespReady_RdyIn,
   output logic [1:0]                 AxiWriteRespResponse_DatOut,
   input  logic                       AxiReadAddrValid_ValIn,
   output logic                       AxiReadAddrReady_RdyOut,
   input  logic [AddrWidth_Gen-1:0]   AxiReadAddrAddress_AdrIn,
   input  logic [2:0]                 AxiReadAddrProt_DatIn,
   output logic                       AxiReadDataValid_ValOut,
   input  logic                       AxiReadDataReady_RdyIn,
   output logic [1:0]                 AxiReadDataResponse_DatOut,
   output logic [DataWidth_Gen-1:0]   AxiReadDataData_DatOut
);

   localparam int         STRB_W    = DataWidth_Gen / 8;
   localparam int         B         = log2_fn(STRB_W);
   localparam int         HI        = B + RamAddrWidth_Gen;
   localparam bit         HAS_WAIT  = (WaitCycles_Gen > 0);
   localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WaitCycles_Gen - 1) : 4'd0;
`ifdef AXI_SLV_ID_REG_EN
   localparam bit         ID_EN     = 1'b1;
`else
   localparam bit         ID_EN     = 1'b0;
`endif
   localparam logic [DataWidth_Gen-1:0] ID_WORD = DataWidth_Gen'(IdValue_Gen);

   function automatic logic is_oor(input logic [AddrWidth_Gen-1:0] a);
      return |(a >> HI);
   endfunction

   function automatic logic [RamAddrWidth_Gen-1:0] word_of(input logic [AddrWidth_Gen-1:0] a);
      return a[HI-1:B];
   endfunction

   function automatic logic is_id_word(input logic [AddrWidth_Gen-1:0] a);
      return ID_EN && !is_oor(a) && (word_of(a) == '0);
   endfunction

   logic unused_prot;
   assign unused_prot = ^{AxiWriteAddrProt_DatIn, AxiReadAddrProt_DatIn};

   // ---------------------------------------------------------------- write
   wr_state_e                 wr_state_q, wr_state_d;
   logic                      aw_held_q, aw_held_d;
   logic                      w_held_q, w_held_d;
   logic [AddrWidth_Gen-1:0]  awaddr_q, awaddr_d;
   logic [DataWidth_Gen-1:0]  wdata_q, wdata_d;
   logic [STRB_W-1:0]         wstrb_q, wstrb_d;
   logic [3:0]                wcnt_q, wcnt_d;
   logic                      awready_q, awready_d;
   logic                      wready_q, wready_d;
   logic                      bvalid_q, bvalid_d;
   logic [1:0]                bresp_q, bresp_d;

   logic                      aw_hs, w_hs;
   logic [AddrWidth_Gen-1:0]  wr_addr;
   logic [DataWidth_Gen-1:0]  wr_data;
   logic [STRB_W-1:0]         wr_strb;
   logic                      wr_commit;
   logic                      ram_we;

   assign aw_hs     = AxiWriteAddrValid_ValIn && awready_q;
   assign w_hs      = AxiWriteDataValid_ValIn && wready_q;
   // Bypass the holding registers so a zero-wait write lands on the capture edge.
   assign wr_addr   = aw_held_q ? awaddr_q : AxiWriteAddrAddress_AdrIn;
   assign wr_data   = w_held_q  ? wdata_q  : AxiWriteDataData_DatIn;
   assign wr_strb   = w_held_q  ? wstrb_q  : AxiWriteDataStrobe_DatIn;
   assign wr_commit = !is_oor(wr_addr) && !is_id_word(wr_addr);

   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      awaddr_d   = awaddr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      wcnt_d     = wcnt_q;
      bresp_d    = bresp_q;
      ram_we     = 1'b0;

      case (wr_state_q)
         W_IDLE, W_COLLECT: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               awaddr_d  = AxiWriteAddrAddress_AdrIn;
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               wdata_d  = AxiWriteDataData_DatIn;
               wstrb_d  = AxiWriteDataStrobe_DatIn;
            end
            if (aw_held_d && w_held_d) begin
               bresp_d = is_oor(wr_addr) ? RESP_SLVERR : RESP_OKAY;
               if (HAS_WAIT) begin
                  wr_state_d = W_WAIT;
                  wcnt_d     = WAIT_LOAD;
               end else begin
                  wr_state_d = W_RESP;
                  ram_we     = wr_commit;
               end
            end else if (aw_held_d || w_held_d) begin
               wr_state_d = W_COLLECT;
            end
         end
         W_WAIT: begin
            if (wcnt_q == 4'd0) begin
               wr_state_d = W_RESP;
               ram_we     = wr_commit;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         W_RESP: begin
            if (AxiWriteRespReady_RdyIn) begin
               wr_state_d = W_IDLE;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               bresp_d    = RESP_OKAY;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase

      bvalid_d  = (wr_state_d == W_RESP);
      awready_d = (wr_state_d == W_IDLE) || ((wr_state_d == W_COLLECT) && !aw_held_d);
      wready_d  = (wr_state_d == W_IDLE) || ((wr_state_d == W_COLLECT) && !w_held_d);
   end

   // ----------------------------------------------------------------- read
   rd_state_e                 rd_state_q, rd_state_d;
   logic [AddrWidth_Gen-1:0]  araddr_q, araddr_d;
   logic [3:0]                rcnt_q, rcnt_d;
   logic                      arready_q, arready_d;
   logic                      rvalid_q, rvalid_d;
   logic [1:0]                rresp_q, rresp_d;
   rd_src_e                   rd_src_q, rd_src_d;

   logic                      ar_hs;
   logic                      rd_issue;
   logic [AddrWidth_Gen-1:0]  rd_addr;
   logic [DataWidth_Gen-1:0]  ram_rdata;

   assign ar_hs   = AxiReadAddrValid_ValIn && arready_q;
   assign rd_addr = (rd_state_q == R_IDLE) ? AxiReadAddrAddress_AdrIn : araddr_q;

   always_comb begin
      rd_state_d = rd_state_q;
      araddr_d   = araddr_q;
      rcnt_d     = rcnt_q;
      rresp_d    = rresp_q;
      rd_src_d   = rd_src_q;
      rd_issue   = 1'b0;

      case (rd_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               araddr_d = AxiReadAddrAddress_AdrIn;
               if (HAS_WAIT) begin
                  rd_state_d = R_WAIT;
                  rcnt_d     = WAIT_LOAD;
               end else begin
                  rd_state_d = R_DATA;
                  rd_issue   = 1'b1;
               end
            end
         end
         R_WAIT: begin
            if (rcnt_q == 4'd0) begin
               rd_state_d = R_DATA;
               rd_issue   = 1'b1;
            end else begin
               rcnt_d = rcnt_q - 4'd1;
            end
         end
         R_DATA: begin
            if (AxiReadDataReady_RdyIn) begin
               rd_state_d = R_IDLE;
            end
         end
         default: rd_state_d = R_IDLE;
      endcase

      if (rd_issue) begin
         if (is_oor(rd_addr)) begin
            rresp_d  = RESP_SLVERR;
            rd_src_d = SRC_ZERO;
         end else if (is_id_word(rd_addr)) begin
            rresp_d  = RESP_OKAY;
            rd_src_d = SRC_ID;
         end else begin
            rresp_d  = RESP_OKAY;
            rd_src_d = SRC_RAM;
         end
      end

      rvalid_d  = (rd_state_d == R_DATA);
      arready_d = (rd_state_d == R_IDLE);
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
      if (!SysRstN_RstIn) begin
         wr_state_q <= W_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         wcnt_q     <= 4'd0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rd_state_q <= R_IDLE;
         araddr_q   <= '0;
         rcnt_q     <= 4'd0;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rresp_q    <= RESP_OKAY;
         rd_src_q   <= SRC_ZERO;
      end else begin
         wr_state_q <= wr_state_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         awaddr_q   <= awaddr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         wcnt_q     <= wcnt_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rd_state_q <= rd_state_d;
         araddr_q   <= araddr_d;
         rcnt_q     <= rcnt_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rd_src_q   <= rd_src_d;
      end
   end

   axi_lite_bram_be #(
      .DATA_W (DataWidth_Gen),
      .ADDR_W (RamAddrWidth_Gen)
   ) u_bram (
      .clk     (SysClk_ClkIn),
      .i_we    (ram_we),
      .i_waddr (word_of(wr_addr)),
      .i_wdata (wr_data),
      .i_wstrb (wr_strb),
      .i_re    (rd_issue),
      .i_raddr (word_of(rd_addr)),
      .o_rdata (ram_rdata)
   );

   // The RAM output register has no reset, so the source select gates it.
   always_comb begin
      case (rd_src_q)
         SRC_RAM: AxiReadDataData_DatOut = ram_rdata;
         SRC_ID:  AxiReadDataData_DatOut = ID_WORD;
         default: AxiReadDataData_DatOut = '0;
      endcase
   end

   assign AxiWriteAddrReady_RdyOut    = awready_q;
   assign AxiWriteDataReady_RdyOut    = wready_q;
   assign AxiWriteRespValid_ValOut    = bvalid_q;
   assign AxiWriteRespResponse_DatOut = bresp_q;
   assign AxiReadAddrReady_RdyOut     = arready_q;
   assign AxiReadDataValid_ValOut     = rvalid_q;
   assign AxiReadDataResponse_DatOut  = rresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_ram_slave_gen2.sv
`default_nettype none
// ============================================================================
// tb_axi_lite_ram_slave_gen2
// Scoreboard bench: instance 0 has no wait states, instance 1 has three.
// Revision: 1.0
// ============================================================================
module tb_axi_lite_ram_slave_gen2;

   localparam int         NDUT   = 2;
   localparam logic [1:0] OK     = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        awvalid [NDUT], awready [NDUT], wvalid [NDUT], wready [NDUT];
   logic        bvalid  [NDUT], bready  [NDUT], arvalid [NDUT], arready [NDUT];
   logic        rvalid  [NDUT], rready  [NDUT];
   logic [15:0] awaddr  [NDUT], araddr  [NDUT];
   logic [31:0] wdata   [NDUT], rdata   [NDUT];
   logic [3:0]  wstrb   [NDUT];
   logic [1:0]  bresp   [NDUT], rresp   [NDUT];
   logic [2:0]  prot_c;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      axi_lite_ram_slave_gen2 #(
         .DataWidth_Gen    (32),
         .AddrWidth_Gen    (16),
         .RamAddrWidth_Gen (10),
         .WaitCycles_Gen   (g * 3),
         .IdValue_Gen      (32'hDA5A_0002)
      ) u_dut (
         .SysClk_ClkIn                (clk),
         .SysRstN_RstIn               (rst_n),
         .AxiWriteAddrValid_ValIn     (awvalid[g]),
         .AxiWriteAddrReady_RdyOut    (awready[g]),
         .AxiWriteAddrAddress_AdrIn   (awaddr[g]),
         .AxiWriteAddrProt_DatIn      (prot_c),
         .AxiWriteDataValid_ValIn     (wvalid[g]),
         .AxiWriteDataReady_RdyOut    (wready[g]),
         .AxiWriteDataData_DatIn      (wdata[g]),
         .AxiWriteDataStrobe_DatIn    (wstrb[g]),
         .AxiWriteRespValid_ValOut    (bvalid[g]),
         .AxiWriteRespReady_RdyIn     (bready[g]),
         .AxiWriteRespResponse_DatOut (bresp[g]),
         .AxiReadAddrValid_ValIn      (arvalid[g]),
         .AxiReadAddrReady_RdyOut     (arready[g]),
         .AxiReadAddrAddress_AdrIn    (araddr[g]),
         .AxiReadAddrProt_DatIn       (prot_c),
         .AxiReadDataValid_ValOut     (rvalid[g]),
         .AxiReadDataReady_RdyIn      (rready[g]),
         .AxiReadDataResponse_DatOut  (rresp[g]),
         .AxiReadDataData_DatOut      (rdata[g])
      );
   end

   typedef struct {
      int          dut;
      logic [1:0]  resp;
      logic [31:0] data;
   } exp_t;

   exp_t bq[$];
   exp_t rq[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
   endfunction

   function automatic logic [31:0] exp_w0(input logic [31:0] ram_val);
`ifdef AXI_SLV_ID_REG_EN
      return 32'hDA5A_0002 | (ram_val & 32'h0);
`else
      return ram_val;
`endif
   endfunction

   // Monitor: a handshake seen at a falling edge completes on the next rising edge.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < NDUT; d++) begin
         if (bvalid[d] && bready[d]) begin
            if (bq.size() == 0) begin
               fail_now("b_beat_unexpected");
            end else begin
               e = bq.pop_front();
               check("b_beat_dut", d, e.dut);
               check("bresp", bresp[d], e.resp);
            end
         end
         if (rvalid[d] && rready[d]) begin
            if (rq.size() == 0) begin
               fail_now("r_beat_unexpected");
            end else begin
               e = rq.pop_front();
               check("r_beat_dut", d, e.dut);
               check("rresp", rresp[d], e.resp);
               check("rdata", rdata[d], e.data);
            end
         end
      end
   end

   task automatic do_write(input int d, input logic [15:0] a, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input int bhold,
                           input logic [1:0] exp_resp);
      bit aw_done, w_done, aw_fire, w_fire;
      int cyc, lat;
      aw_done = 0; w_done = 0; cyc = 0; lat = 0;
      bq.push_back('{dut: d, resp: exp_resp, data: 32'h0});
      @(posedge clk); #1;
      awaddr[d]  = a;
      wdata[d]   = data;
      wstrb[d]   = strb;
      wvalid[d]  = 1'b1;
      awvalid[d] = (w_lead == 0);
      while (!(aw_done && w_done) && cyc < 40) begin
         @(negedge clk);
         if (w_done && !aw_done) begin
            check("awready_before_aw", awready[d], 1'b1);
            check("wready_after_w", wready[d], 1'b0);
         end
         aw_fire = awvalid[d] && awready[d];
         w_fire  = wvalid[d] && wready[d];
         @(posedge clk); #1;
         cyc++;
         if (aw_fire) begin aw_done = 1; awvalid[d] = 1'b0; end
         if (w_fire)  begin w_done  = 1; wvalid[d]  = 1'b0; end
         if (cyc == w_lead && !aw_done) awvalid[d] = 1'b1;
      end
      if (!(aw_done && w_done)) fail_now("write_handshake_timeout");
      do begin
         @(negedge clk);
         lat++;
      end while (!bvalid[d] && lat < 40);
      check("bvalid_latency", lat, d * 3 + 1);
      check("aw_w_ready_in_resp", {awready[d], wready[d]}, 2'b00);
      for (int i = 0; i < bhold; i++) begin
         @(negedge clk);
         check("bvalid_held", bvalid[d], 1'b1);
      end
      @(posedge clk); #1 bready[d] = 1'b1;
      @(posedge clk); #1 bready[d] = 1'b0;
      @(negedge clk);
      check("bvalid_after_b", bvalid[d], 1'b0);
      check("awready_after_b", awready[d], 1'b1);
   endtask

   task automatic do_read(input int d, input logic [15:0] a, input logic [1:0] exp_resp,
                          input logic [31:0] exp_data, input int rhold);
      int g, lat;
      g = 0; lat = 0;
      rq.push_back('{dut: d, resp: exp_resp, data: exp_data});
      @(posedge clk); #1;
      araddr[d]  = a;
      arvalid[d] = 1'b1;
      do begin
         @(negedge clk);
         g++;
      end while (!arready[d] && g < 40);
      @(posedge clk); #1 arvalid[d] = 1'b0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rvalid[d] && lat < 40);
      check("rvalid_latency", lat, d * 3 + 1);
      check("arready_in_data", arready[d], 1'b0);
      for (int i = 0; i < rhold; i++) begin
         @(negedge clk);
         check("rdata_stable", rdata[d], exp_data);
         check("rresp_stable", rresp[d], exp_resp);
         check("arready_low_hold", arready[d], 1'b0);
      end
      @(posedge clk); #1 rready[d] = 1'b1;
      @(posedge clk); #1 rready[d] = 1'b0;
      @(negedge clk);
      check("rvalid_after_r", rvalid[d], 1'b0);
      check("arready_after_r", arready[d], 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      prot_c = 3'b000;
      for (int d = 0; d < NDUT; d++) begin
         awvalid[d] = 0; wvalid[d] = 0; bready[d] = 0; arvalid[d] = 0; rready[d] = 0;
         awaddr[d] = '0; araddr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
      end
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         check("reset_outputs", {awready[d], wready[d], bvalid[d], bresp[d], arready[d],
                                 rvalid[d], rresp[d], rdata[d]}, 41'd0);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Zero wait states
      do_write(0, 16'h0010, 32'h1234_5678, 4'hF, 0, 0, OK);
      do_read (0, 16'h0010, OK, 32'h1234_5678, 0);
      do_read (0, 16'h0013, OK, 32'h1234_5678, 0);
      do_write(0, 16'h0020, 32'hAABB_CCDD, 4'hF, 0, 0, OK);
      do_write(0, 16'h0020, 32'h0000_0011, 4'b0001, 0, 2, OK);
      do_read (0, 16'h0020, OK, 32'hAABB_CC11, 0);
      do_write(0, 16'h0030, 32'h5555_5555, 4'hF, 0, 0, OK);
      do_write(0, 16'h0030, 32'h0000_0000, 4'h0, 0, 0, OK);
      do_read (0, 16'h0030, OK, 32'h5555_5555, 0);
      do_write(0, 16'h0FFC, 32'h0F0F_1E1E, 4'hF, 1, 0, OK);
      do_read (0, 16'h0FFC, OK, 32'h0F0F_1E1E, 0);
      do_write(0, 16'h0000, 32'hCAFE_BABE, 4'hF, 0, 0, OK);
      do_write(0, 16'h1000, 32'hDEAD_BEEF, 4'hF, 0, 0, SLVERR);
      do_read (0, 16'h1000, SLVERR, 32'h0, 3);
      do_read (0, 16'h0000, OK, exp_w0(32'hCAFE_BABE), 0);
      do_write(0, 16'h0000, 32'hFFFF_FFFF, 4'hF, 0, 0, OK);
      do_read (0, 16'h0000, OK, exp_w0(32'hFFFF_FFFF), 0);

      // Three wait states
      do_write(1, 16'h0040, 32'h1357_2468, 4'hF, 3, 5, OK);
      do_write(1, 16'h0044, 32'h9ABC_DEF0, 4'b1100, 0, 0, OK);
      do_read (1, 16'h0040, OK, 32'h1357_2468, 10);
      do_read (1, 16'h8004, SLVERR, 32'h0, 0);

      // Reset while a read beat is pending
      @(posedge clk); #1;
      araddr[1]  = 16'h0040;
      arvalid[1] = 1'b1;
      rready[1]  = 1'b0;
      @(posedge clk); #1 arvalid[1] = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("rvalid_before_reset", rvalid[1], 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("outputs_in_reset", {awready[1], wready[1], bvalid[1], bresp[1], arready[1],
                                 rvalid[1], rresp[1], rdata[1]}, 41'd0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      rready[1] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("no_stale_r", rvalid[1], 1'b0);
      end
      rready[1] = 1'b0;
      check("arready_after_reset", arready[1], 1'b1);

      check("b_queue_drained", bq.size(), 0);
      check("r_queue_drained", rq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_lite_ram_slave_gen2.md
Name: axi_lite_ram_slave_gen2

Overview:
Parametrised AXI4-Lite slave backed by an internal register RAM. It is the successor to the fixed 32-bit/16-bit-address dummy slave. Adds configurable data and address width, byte-strobe writes, programmable wait states, and SLVERR on out-of-range accesses. Used as a bus-fabric test target and scratch memory behind the AXI interconnect.

Parameters:
DataWidth_Gen, 32, bus data width; 32 or 64 only.
AddrWidth_Gen, 16, AXI address width.
RamAddrWidth_Gen, 10, log2 of RAM depth in words.
WaitCycles_Gen, 0, extra cycles between request capture and response; range 0..15.
IdValue_Gen, 32'hDA5A_0002, ID word; used only with the optional feature.

Ports:
SysClk_ClkIn  in  1  clock; all logic on its rising edge.
SysRstN_RstIn  in  1  asynchronous active-low reset.
AxiWriteAddrValid_ValIn / AxiWriteAddrReady_RdyOut  in/out  1  AW handshake.
AxiWriteAddrAddress_AdrIn  in  AddrWidth_Gen  AWADDR.
AxiWriteAddrProt_DatIn  in  3  AWPROT; ignored.
AxiWriteDataValid_ValIn / AxiWriteDataReady_RdyOut  in/out  1  W handshake.
AxiWriteDataData_DatIn  in  DataWidth_Gen  WDATA.
AxiWriteDataStrobe_DatIn  in  DataWidth_Gen/8  WSTRB.
AxiWriteRespValid_ValOut / AxiWriteRespReady_RdyIn  out/in  1  B handshake.
AxiWriteRespResponse_DatOut  out  2  BRESP.
AxiReadAddrValid_ValIn / AxiReadAddrReady_RdyOut  in/out  1  AR handshake.
AxiReadAddrAddress_AdrIn  in  AddrWidth_Gen  ARADDR.
AxiReadAddrProt_DatIn  in  3  ARPROT; ignored.
AxiReadDataValid_ValOut / AxiReadDataReady_RdyIn  out/in  1  R handshake.
AxiReadDataResponse_DatOut  out  2  RRESP.
AxiReadDataData_DatOut  out  DataWidth_Gen  RDATA.

Behaviour:
- Reset is asynchronous on SysRstN_RstIn low. All outputs go to 0, both FSMs go to Idle, and the wait counters clear. RAM contents are not reset. Reset mid-transaction abandons the transaction; no B or R beat is issued afterwards.
- Word index is addr[B+RamAddrWidth_Gen-1:B], where B = log2(DataWidth_Gen/8). The low B address bits are ignored.
- An access is out of range if any address bit at or above B+RamAddrWidth_Gen is set. Out-of-range writes return BRESP=2'b10 and the RAM is unchanged. Out-of-range reads return RRESP=2'b10 and RDATA=0. In-range accesses return OKAY (2'b00).
- Write FSM states: Idle, Collect, Wait, Resp.
  - Idle: AWREADY=WREADY=1. AW and W may complete in the same cycle or in either order, and each is latched independently. The handshake that arrives first drops its READY until the other arrives (state Collect).
  - Once both are held: go to Wait if WaitCycles_Gen>0, otherwise go straight to Resp.
  - The RAM write happens on the cycle Resp is entered. Only bytes whose WSTRB bit is set are written; WSTRB=0 writes nothing but still responds OKAY.
  - Resp: BVALID=1 and stays high until BREADY is seen, then go to Idle. AW/W READY stay 0 from capture until return to Idle.
- Read FSM states: Idle, Wait, Data.
  - Idle: ARREADY=1. On AR handshake, latch the address and go to Wait, or to Data if WaitCycles_Gen=0.
  - RDATA/RRESP are registered on the cycle Data is entered and stay stable while RVALID=1 and RREADY=0.
  - RVALID deasserts on the handshake; ARREADY reasserts the following cycle.
- Latency with WaitCycles_Gen=N: BVALID asserts N+1 cycles after the later of the AW/W handshakes. RVALID asserts N+1 cycles after the AR handshake.
- Throughput: at most one outstanding write and one outstanding read; the read and write channels run independently.
- Same-cycle RAM write and read capture to the same word: the read returns the old data (read-before-write).
- Wait counter is 4 bits, loaded with N-1 and counting down to 0. No wrap-around is possible.

Optional Feature:
AXI_SLV_ID_REG_EN.
- Defined: word 0 is read-only. Reads of word 0 return IdValue_Gen (zero-extended or truncated to DataWidth_Gen) with OKAY. Writes to word 0 return OKAY and are discarded.
- Undefined: word 0 is ordinary RAM.

Decomposition:
- Shared package axi_lite_pkg: RESP_OKAY/RESP_SLVERR constants, write-FSM and read-FSM state enums, and a log2 helper for B.
- One sub-module, axi_lite_bram_be: byte-enable RAM with one write port and one registered read port, parametrised on width and depth.

Test Plan:
1. DataWidth_Gen=32, N=0. Write 0x1234_5678 to 0x0010 with WSTRB=4'hF, then read 0x0010. Expect BRESP=0, RDATA=0x1234_5678, RVALID exactly 1 cycle after the AR handshake.
2. Write 0xAABB_CCDD to 0x0020, then write 0x0000_0011 to the same address with WSTRB=4'b0001, then read. Expect RDATA=0xAABB_CC11.
3. RamAddrWidth_Gen=10. Write and read address 0x1000. Expect BRESP=2'b10, RRESP=2'b10, RDATA=0. Also read 0x0000 and confirm the RAM is unchanged.
4. N=3. Present W three cycles before AW, and hold BREADY low for 5 cycles. Expect AWREADY to be dropped only after capture, BVALID 4 cycles after the AW handshake, and BVALID held high until BREADY.
5. Hold RREADY low for 10 cycles during a read. Expect RDATA and RRESP stable and ARREADY=0 throughout. Then assert reset mid-transaction: all outputs go to 0 immediately and no stale R beat appears after reset release.
6. With AXI_SLV_ID_REG_EN defined, write 0xFFFF_FFFF to 0x0000, then read 0x0000. Expect BRESP=0 and RDATA=0xDA5A_0002. Without the macro, RDATA=0xFFFF_FFFF.
